// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e   : controller state encoding (idle, shifting, result cycle)
//   DefBinW   : default binary input width
//   DefDigits : default number of packed BCD output digits
//   AddThresh : digit value at or above which the double-dabble correction applies
//   AddVal    : correction added to such a digit before each shift
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned DefBinW   = 32;
    localparam int unsigned DefDigits = 8;

    localparam logic [3:0] AddThresh = 4'd5;
    localparam logic [3:0] AddVal    = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a requester and the converter.
//   start    : conversion request (requester -> converter)
//   bin      : unsigned binary operand
//   dp_in    : decimal-point pattern travelling alongside the operand
//   busy     : conversion in progress
//   done     : one-cycle pulse, results freshly loaded
//   bcd      : packed BCD result, digit k at [4k+3:4k]
//   dp_out   : dp_in captured with the operand
//   overflow : operand did not fit in DIGITS decimal digits
interface bin2bcd_seq_if
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W  = DefBinW,
    parameter int unsigned DIGITS = DefDigits
) ();

    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic [DIGITS-1:0]     dp_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     dp_out;
    logic                  overflow;

    modport master (
        output start, bin, dp_in,
        input  busy, done, bcd, dp_out, overflow
    );

    modport slave (
        input  start, bin, dp_in,
        output busy, done, bcd, dp_out, overflow
    );

endinterface

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Double-dabble digit corrector: adds 3 to a BCD digit that is 5 or more, so that the
// following left shift carries correctly into the next decimal digit.
//   digit_i : accumulator digit before the shift
//   digit_o : corrected digit
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= AddThresh) begin
            digit_o = digit_i + AddVal;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : request/result bundle (slave side), see bin2bcd_seq_if
// A request accepted in idle takes BIN_W shift cycles followed by one result cycle.
// The accumulator carries two spare digits so any BIN_W-bit operand converts exactly;
// nonzero spare digits flag overflow and saturate the visible result to all nines.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W  = DefBinW,
    parameter int unsigned DIGITS = DefDigits
) (
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);

    localparam int unsigned AccDigits = DIGITS + 2;
    localparam int unsigned AccW      = 4 * AccDigits;
    localparam int unsigned OutW      = 4 * DIGITS;
    localparam int unsigned CntW      = $clog2(BIN_W + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(BIN_W - 1);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [AccW-1:0]     acc_q, acc_d;
    logic [BIN_W-1:0]    op_q, op_d;
    logic [DIGITS-1:0]   dp_cap_q, dp_cap_d;
    logic [OutW-1:0]     bcd_q, bcd_d;
    logic [DIGITS-1:0]   dp_out_q, dp_out_d;
    logic                ovf_q, ovf_d;

    logic [AccW-1:0]     acc_adj;
    logic [AccW-1:0]     acc_shift;
    logic                ovf_next;

    for (genvar g = 0; g < AccDigits; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q[4*g +: 4]),
            .digit_o (acc_adj[4*g +: 4])
        );
    end

    // Operand MSB shifts into the accumulator LSB.
    assign acc_shift = {acc_adj[AccW-2:0], op_q[BIN_W-1]};
    assign ovf_next  = |acc_shift[AccW-1:OutW];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        op_d     = op_q;
        dp_cap_d = dp_cap_q;
        bcd_d    = bcd_q;
        dp_out_d = dp_out_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StShift;
                    op_d     = bus.bin;
                    dp_cap_d = bus.dp_in;
                    cnt_d    = '0;
                    acc_d    = '0;
                end
            end
            StShift: begin
                acc_d = acc_shift;
                op_d  = op_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d  = StDone;
                    bcd_d    = ovf_next ? {DIGITS{4'h9}} : acc_shift[OutW-1:0];
                    dp_out_d = dp_cap_q;
                    ovf_d    = ovf_next;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            dp_cap_q <= '0;
            bcd_q    <= '0;
            dp_out_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            dp_cap_q <= dp_cap_d;
            bcd_q    <= bcd_d;
            dp_out_q <= dp_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone);
    assign bus.bcd      = bcd_q;
    assign bus.dp_out   = dp_out_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, randomized operands against a
// decimal reference model, and hand-written sequences for the multi-cycle corner cases.
module tb_bin2bcd_seq;

    localparam int unsigned BinW   = 32;
    localparam int unsigned Digits = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    bin2bcd_seq_if #(.BIN_W(BinW), .DIGITS(Digits)) bus ();

    bin2bcd_seq #(.BIN_W(BinW), .DIGITS(Digits)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bin;
        logic [7:0]  dp;
        logic [31:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by repeated division, saturating above 8 digits.
    function automatic void model(input logic [31:0] v, output logic [31:0] b, output logic o);
        longint unsigned x;
        x = longint'(v);
        b = '0;
        o = 1'b0;
        if (x > 64'd99999999) begin
            b = 32'h99999999;
            o = 1'b1;
        end else begin
            for (int i = 0; i < 8; i++) begin
                b[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion from idle, checking latency, busy, the done pulse and results.
    task automatic do_conv(input logic [31:0] v, input logic [7:0] dp, input string name);
        logic [31:0] eb;
        logic        eo;
        int          cyc;
        logic        busy_ok;
        model(v, eb, eo);
        bus.start = 1'b1;
        bus.bin   = v;
        bus.dp_in = dp;
        tick();
        bus.start = 1'b0;
        bus.bin   = $urandom;
        bus.dp_in = 8'($urandom);
        cyc = 0;
        busy_ok = 1'b1;
        while (!bus.done && cyc < 100) begin
            if (!bus.busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(BinW));
        check({name, " busy"}, 64'(busy_ok), 64'd1);
        check({name, " bcd"}, 64'(bus.bcd), 64'(eb));
        check({name, " dp_out"}, 64'(bus.dp_out), 64'(dp));
        check({name, " overflow"}, 64'(bus.overflow), 64'(eo));
        tick();
        check({name, " done width"}, {62'd0, bus.done, bus.busy}, 64'd0);
    endtask

    initial begin
        vec_t vecs[6];
        logic [31:0] v;
        logic [31:0] hold_bcd;
        int          dones;
        int          done_at[$];
        int          idle_cnt;

        vecs[0] = '{32'd0,          8'h00, 32'h00000000, 1'b0};
        vecs[1] = '{32'h00BC614E,   8'h04, 32'h12345678, 1'b0};
        vecs[2] = '{32'd99999999,   8'h80, 32'h99999999, 1'b0};
        vecs[3] = '{32'd100000000,  8'h01, 32'h99999999, 1'b1};
        vecs[4] = '{32'hFFFFFFFF,   8'hFF, 32'h99999999, 1'b1};
        vecs[5] = '{32'd9,          8'h55, 32'h00000009, 1'b0};

        bus.start = 1'b0;
        bus.bin   = '0;
        bus.dp_in = '0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset outputs", {bus.busy, bus.done, bus.overflow, bus.dp_out, bus.bcd},
              64'd0);

        // Table: the table expectations are independent of the model.
        for (int i = 0; i < 6; i++) begin
            logic [31:0] eb;
            logic        eo;
            model(vecs[i].bin, eb, eo);
            check($sformatf("model vec%0d", i), {31'd0, eo, eb},
                  {31'd0, vecs[i].exp_ovf, vecs[i].exp_bcd});
            do_conv(vecs[i].bin, vecs[i].dp, $sformatf("vec%0d", i));
        end

        // Randomized operands, mixing in-range and full-range values.
        for (int i = 0; i < 16; i++) begin
            v = (i % 2 == 0) ? $urandom_range(0, 99999999) : $urandom;
            do_conv(v, 8'($urandom), $sformatf("rand%0d", i));
        end

        // Results hold between conversions while inputs wander.
        hold_bcd = bus.bcd;
        for (int i = 0; i < 5; i++) begin
            bus.bin = $urandom;
            tick();
        end
        check("hold bcd", 64'(bus.bcd), 64'(hold_bcd));

        // Start while busy is ignored; inputs changed mid-conversion have no effect.
        bus.start = 1'b1;
        bus.bin   = 32'd42;
        bus.dp_in = 8'h11;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.start = 1'b1;
        bus.bin   = 32'd7;
        bus.dp_in = 8'hFF;
        tick();
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done) begin
                dones++;
                check("ignore bcd", 64'(bus.bcd), 64'h42);
                check("ignore dp_out", 64'(bus.dp_out), 64'h11);
            end
            tick();
        end
        check("ignore done count", 64'(dones), 64'd1);

        // Reset aborts a conversion: idle next cycle, outputs cleared, no done pulse.
        bus.start = 1'b1;
        bus.bin   = 32'd500;
        bus.dp_in = 8'h02;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort state", {bus.busy, bus.done, bus.overflow, bus.dp_out, bus.bcd}, 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dones++;
            tick();
        end
        check("abort no done", 64'(dones), 64'd0);
        do_conv(32'd500, 8'h02, "after abort");

        // Reset has priority over start.
        bus.start = 1'b1;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        check("reset over start", 64'(bus.busy), 64'd0);

        // Start held high: back-to-back conversions every BinW+2 cycles.
        bus.bin   = 32'd1;
        bus.dp_in = 8'h00;
        bus.start = 1'b1;
        idle_cnt  = 0;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (bus.done) done_at.push_back(c);
            if (done_at.size() == 1 && !bus.busy) idle_cnt++;
        end
        bus.start = 1'b0;
        check("b2b done count", 64'(done_at.size()), 64'd3);
        if (done_at.size() >= 3) begin
            check("b2b period 1", 64'(done_at[1] - done_at[0]), 64'(BinW + 2));
            check("b2b period 2", 64'(done_at[2] - done_at[1]), 64'(BinW + 2));
        end
        check("b2b idle gap", 64'(idle_cnt), 64'd1);
        check("b2b bcd", 64'(bus.bcd), 64'h1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
